bist_controller: RTL and testbench

BIST_CONTROLLER -- requirements
Module: bist_controller

---
 rtl/bist_pkg.sv | 20 ++
 rtl/bist_lfsr8.sv | 27 ++
 rtl/bist_controller.sv | 142 ++++++++++++++
 tb/tb_bist_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types, constants and step function for the BIST controller
package bist_pkg;

    localparam int         CNT_W    = 16;
    localparam logic [7:0] TAP_MASK = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Feedback is the parity of the tapped bits (7,5,4,3) shifted in at bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & TAP_MASK)};
    endfunction

endpackage

// File: rtl/bist_lfsr8.sv
// rtl/bist_lfsr8.sv - 8-bit tap-masked shift register with parallel-XOR input and load
module bist_lfsr8
    import bist_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       C,
    input  logic       RN,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] q
);

    // With din tied to zero this is a plain LFSR; with din fed it is a MISR.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= lfsr_step(q) ^ din;
        end
    end

endmodule

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - LFSR pattern generator and MISR signature compactor with pass/fail
module bist_controller
    import bist_pkg::*;
#(
    parameter int         NPAT    = 16,
    parameter int         CUT_LAT = 0,
    parameter logic [7:0] SEED    = 8'h01
) (
    input  logic       C,
    input  logic       RN,
    input  logic       start,
    input  logic [7:0] golden,
    output logic [7:0] cut_in,
    input  logic [7:0] cut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);

    localparam logic [CNT_W-1:0] LAST_PAT   = CNT_W'(NPAT - 1);
    localparam logic [1:0]       FLUSH_LAST = 2'(CUT_LAT);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       fcnt;
    logic [7:0]       lfsr_q;
    logic [7:0]       misr_q;
    logic             is_load;
    logic             issue;
    logic             absorb;

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        is_load = 1'b0;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        cut_in  = 8'h00;
        case (state)
            ST_IDLE: begin
                if (start) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                is_load = 1'b1;
                busy    = 1'b1;
                state_n = ST_RUN;
            end
            ST_RUN: begin
                issue  = 1'b1;
                busy   = 1'b1;
                cut_in = lfsr_q;
                if (cnt == LAST_PAT) state_n = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (fcnt == FLUSH_LAST) state_n = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_n = ST_LOAD;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            cnt <= '0;
        end else if (is_load) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            fcnt <= 2'd0;
        end else if (state == ST_FLUSH) begin
            fcnt <= fcnt + 2'd1;
        end else begin
            fcnt <= 2'd0;
        end
    end

    // The issue flag itself is the first stage of the valid pipe, so a
    // combinational CUT is absorbed in the same cycle its pattern is driven.
    generate
        if (CUT_LAT == 0) begin : g_nopipe
            assign absorb = issue;
        end else begin : g_pipe
            logic [CUT_LAT-1:0] vpipe;
            always_ff @(posedge C or negedge RN) begin
                if (!RN) begin
                    vpipe <= '0;
                end else if (is_load) begin
                    vpipe <= '0;
                end else begin
                    vpipe[0] <= issue;
                    for (int i = 1; i < CUT_LAT; i++) begin
                        vpipe[i] <= vpipe[i-1];
                    end
                end
            end
            assign absorb = vpipe[CUT_LAT-1];
        end
    endgenerate

    bist_lfsr8 #(.RST_VAL(SEED)) u_lfsr (
        .C        (C),
        .RN       (RN),
        .load     (is_load),
        .load_val (SEED),
        .en       (issue),
        .din      (8'h00),
        .q        (lfsr_q)
    );

    bist_lfsr8 #(.RST_VAL(8'h00)) u_misr (
        .C        (C),
        .RN       (RN),
        .load     (is_load),
        .load_val (8'h00),
        .en       (absorb),
        .din      (cut_out),
        .q        (misr_q)
    );

    assign signature = misr_q;
    assign pass      = done && (misr_q == golden);

endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - scoreboard bench over several controller configurations
module tb_bist_controller;

    localparam int NI = 5;

    logic       C = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] map [256];
    bit         fin [NI];

    always #5 C = ~C;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    function automatic logic [7:0] lstep(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // kind 0: random lookup table, 1: identity, 2: constant zero
    function automatic logic [7:0] resp(input int kind, input logic [7:0] p);
        if (kind == 0) return map[p];
        if (kind == 1) return p;
        return 8'h00;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int         NP   = (g == 2) ? 256 : (g == 3) ? 1 : 6;
        localparam int         LAT  = (g == 1) ? 2 : (g == 3) ? 1 : 0;
        localparam int         KIND = (g == 0 || g == 3) ? 0 : (g == 2) ? 2 : 1;
        localparam logic [7:0] SD   = 8'h01;

        logic       rn = 1'b1;
        logic       start = 1'b0;
        logic [7:0] golden = 8'h00;
        logic [7:0] cut_in, cut_out, signature, tap;
        logic       busy, done, pass;
        logic [7:0] dl [4];
        logic [7:0] pat_q [$];
        logic [7:0] sig_q [$];
        int         bcnt = 0;
        bit         have_rec = 0;
        logic [7:0] rec, pp;

        bist_controller #(.NPAT(NP), .CUT_LAT(LAT), .SEED(SD)) dut (
            .C         (C),
            .RN        (rn),
            .start     (start),
            .golden    (golden),
            .cut_in    (cut_in),
            .cut_out   (cut_out),
            .busy      (busy),
            .done      (done),
            .pass      (pass),
            .signature (signature)
        );

        always @(posedge C) begin
            dl[0] <= cut_in;
            for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
        end

        always_comb begin
            tap     = (LAT == 0) ? cut_in : dl[(LAT == 0) ? 0 : LAT - 1];
            cut_out = (KIND == 0) ? map[tap] : (KIND == 1) ? tap : 8'h00;
        end

        always @(negedge C) begin
            if (!rn) begin
                bcnt     = 0;
                have_rec = 0;
            end else begin
                if (busy) begin
                    if (bcnt >= 1 && bcnt <= NP) begin
                        chk($sformatf("g%0d pattern nonzero", g), int'(cut_in != 8'h00), 1);
                        if (pat_q.size() == 0) begin
                            fail_now($sformatf("g%0d pattern expected in queue", g));
                        end else begin
                            pp = pat_q.pop_front();
                            chk($sformatf("g%0d cut_in pattern %0d", g, bcnt - 1), cut_in, pp);
                        end
                        if (bcnt == 256) chk($sformatf("g%0d pattern 255 equals seed", g), cut_in, SD);
                    end else begin
                        chk($sformatf("g%0d cut_in zero in load/flush", g), cut_in, 0);
                    end
                    bcnt++;
                end else begin
                    chk($sformatf("g%0d cut_in zero when idle", g), cut_in, 0);
                    if (bcnt > 0) begin
                        chk($sformatf("g%0d busy length", g), bcnt, NP + LAT + 2);
                        bcnt = 0;
                    end
                end
                if (done) begin
                    if (!have_rec) begin
                        if (sig_q.size() == 0) begin
                            fail_now($sformatf("g%0d signature expected in queue", g));
                        end else begin
                            rec      = sig_q.pop_front();
                            have_rec = 1;
                        end
                    end
                    if (have_rec) begin
                        chk($sformatf("g%0d signature", g), signature, rec);
                        chk($sformatf("g%0d pass", g), pass, int'(golden == rec));
                    end
                end else begin
                    have_rec = 0;
                end
            end
        end

        task automatic run_once(input bit abort);
            logic [7:0] p, s;
            int         o, ka;
            bit         dbl, seen;
            p = SD;
            s = 8'h00;
            for (int k = 0; k < NP; k++) begin
                pat_q.push_back(p);
                s = lstep(s) ^ resp(KIND, p);
                p = lstep(p);
            end
            sig_q.push_back(s);
            dbl  = 1'($urandom_range(0, 1));
            o    = $urandom_range(2, NP + LAT + 2);
            ka   = (NP > 3) ? 3 : NP - 1;
            seen = 0;
            @(negedge C);
            golden = $urandom_range(0, 1) ? s : 8'($urandom);
            start  = 1'b1;
            @(negedge C);
            start = 1'b0;
            for (int k = 2; k < NP + LAT + 40; k++) begin
                @(negedge C);
                start = dbl && (k == o);
                if (abort && k == ka + 2) begin
                    start = 1'b0;
                    #2 rn = 1'b0;
                    #1;
                    chk($sformatf("g%0d reset busy", g), busy, 0);
                    chk($sformatf("g%0d reset done", g), done, 0);
                    chk($sformatf("g%0d reset pass", g), pass, 0);
                    chk($sformatf("g%0d reset cut_in", g), cut_in, 0);
                    chk($sformatf("g%0d reset signature", g), signature, 0);
                    pat_q.delete();
                    sig_q.delete();
                    @(negedge C);
                    #2 rn = 1'b1;
                    return;
                end
                if (done) begin
                    seen = 1;
                    break;
                end
            end
            start = 1'b0;
            if (!seen) begin
                fail_now($sformatf("g%0d done within budget", g));
                return;
            end
            @(posedge C);
            #2 golden = s ^ (8'h01 << $urandom_range(0, 7));
            @(negedge C);
            @(posedge C);
            #2 golden = s;
            @(negedge C);
        endtask

        initial begin
            #1 rn = 1'b0;
            @(negedge C);
            chk($sformatf("g%0d init busy", g), busy, 0);
            chk($sformatf("g%0d init done", g), done, 0);
            chk($sformatf("g%0d init pass", g), pass, 0);
            chk($sformatf("g%0d init cut_in", g), cut_in, 0);
            chk($sformatf("g%0d init signature", g), signature, 0);
            repeat (2) @(negedge C);
            #2 rn = 1'b1;
            for (int r = 0; r < 5; r++) run_once(r == 1);
            repeat (3) @(negedge C);
            fin[g] = 1'b1;
        end
    end

    initial begin
        bit all_fin;
        for (int i = 0; i < 256; i++) map[i] = 8'($urandom);
        all_fin = 0;
        for (int c = 0; c < 20000 && !all_fin; c++) begin
            @(negedge C);
            all_fin = 1;
            for (int i = 0; i < NI; i++) all_fin &= fin[i];
        end
        if (!all_fin) fail_now("watchdog all instances finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
